// File: rtl/mem_byte_assembler_t_pkg.sv
// Shared CPU package: address/byte widths, fetch window size and the
// byte-assembler state encoding.
`timescale 1ns/1ps
`ifndef BYTE
`define BYTE 8
`endif

package mem_byte_assembler_t_pkg;

    localparam int MEM_ADDR_SIZE_DEF = 16;
    localparam int FETCH_BYTES_DEF   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } assembler_state_t;

endpackage

// File: rtl/mem_byte_assembler_t.sv
// Assembles FETCH_BYTES consecutive memory bytes into one instruction window
// for the CPU, with a one-cycle read latency on the byte memory port.
`timescale 1ns/1ps
`ifndef BYTE
`define BYTE 8
`endif

module mem_byte_assembler_t
    import mem_byte_assembler_t_pkg::*;
#(
    parameter int FETCH_BYTES   = FETCH_BYTES_DEF,
    parameter int MEM_ADDR_SIZE = MEM_ADDR_SIZE_DEF
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic                           req_valid_i,
    input  logic [MEM_ADDR_SIZE-1:0]       req_addr_i,
    output logic                           req_ready_o,
    output logic                           rsp_valid_o,
    output logic [FETCH_BYTES*`BYTE-1:0]   rsp_data_o,
    input  logic                           rsp_ready_i,
    input  logic                           flush_i,
    output logic                           mem_re_o,
    output logic [MEM_ADDR_SIZE-1:0]       mem_addr_o,
    input  logic [`BYTE-1:0]               mem_rdata_i
);

    localparam int CNT_W = $clog2(FETCH_BYTES + 1);
    localparam logic [CNT_W-1:0] ISSUE_END = CNT_W'(FETCH_BYTES);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(FETCH_BYTES - 1);

    assembler_state_t           state_reg;
    logic [MEM_ADDR_SIZE-1:0]   base_addr_reg;
    logic [CNT_W-1:0]           issue_cnt_reg;
    logic [CNT_W-1:0]           capture_cnt_reg;
    logic                       rd_pend_reg;
    logic [`BYTE-1:0]           slot_reg [FETCH_BYTES];

    logic reading;
    logic capture;

    // A read is in flight whenever the previous cycle strobed memory; its data
    // is only kept while still in FETCH and not being flushed.
    assign reading = (state_reg == FETCH) && (issue_cnt_reg < ISSUE_END);
    assign capture = (state_reg == FETCH) && rd_pend_reg && !flush_i;

    assign req_ready_o = rstn_i && (state_reg == IDLE) && !flush_i;
    assign rsp_valid_o = (state_reg == RESP);
    assign mem_re_o    = reading;
    assign mem_addr_o  = reading ? base_addr_reg + MEM_ADDR_SIZE'(issue_cnt_reg)
                                 : base_addr_reg;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_reg       <= IDLE;
            base_addr_reg   <= '0;
            issue_cnt_reg   <= '0;
            capture_cnt_reg <= '0;
            rd_pend_reg     <= 1'b0;
        end else if (flush_i) begin
            state_reg       <= IDLE;
            issue_cnt_reg   <= '0;
            capture_cnt_reg <= '0;
            rd_pend_reg     <= 1'b0;
        end else begin
            rd_pend_reg <= reading;
            case (state_reg)
                IDLE: begin
                    if (req_valid_i) begin
                        base_addr_reg   <= req_addr_i;
                        issue_cnt_reg   <= '0;
                        capture_cnt_reg <= '0;
                        state_reg       <= FETCH;
                    end
                end
                FETCH: begin
                    if (reading) begin
                        issue_cnt_reg <= issue_cnt_reg + 1'b1;
                    end
                    if (capture) begin
                        capture_cnt_reg <= capture_cnt_reg + 1'b1;
                        if (capture_cnt_reg == LAST_SLOT) begin
                            state_reg <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // One register per window byte; the last window stays visible after hand-off.
    for (genvar gi = 0; gi < FETCH_BYTES; gi++) begin : g_slot
        always_ff @(posedge clk_i) begin
            if (!rstn_i) begin
                slot_reg[gi] <= '0;
            end else if (capture && (capture_cnt_reg == CNT_W'(gi))) begin
                slot_reg[gi] <= mem_rdata_i;
            end
        end
        assign rsp_data_o[gi*`BYTE +: `BYTE] = slot_reg[gi];
    end

endmodule
